pos_packer: RTL and testbench

POS_PACKER -- requirements
Module: pos_packer

---
 rtl/pos_packer_pkg.sv | 22 ++
 rtl/pos_fifo.sv | 60 ++++++
 rtl/pos_packer.sv | 122 ++++++++++++
 tb/tb_pos_packer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pos_packer_pkg.sv
// Shared definitions for the POS character packer: code points and FSM states.
package pos_packer_pkg;

  localparam logic [4:0] POS_SPACE  = 5'd0;
  localparam logic [4:0] POS_COMMA  = 5'd29;
  localparam logic [4:0] POS_PERIOD = 5'd30;
  localparam logic [4:0] POS_QMARK  = 5'd31;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    EMIT  = 2'd3
  } packerState_t;

  // Only period and question mark end a sentence. The comma is numerically
  // adjacent to them, so it is excluded explicitly to keep that boundary visible.
  function automatic logic isTerminator(input logic [4:0] code);
    return (code != POS_COMMA) && ((code == POS_PERIOD) || (code == POS_QMARK));
  endfunction

endpackage

// File: rtl/pos_fifo.sv
// Small synchronous FIFO holding incoming 5-bit character codes.
module pos_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [4:0] i_din,
  input  logic       i_pop,
  output logic [4:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;

  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rdPtr];

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; no reset needed because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!rst && w_doPush) begin
      r_mem[r_wrPtr] <= i_din;
    end
  end

endmodule

// File: rtl/pos_packer.sv
// Packs up to three 5-bit character codes into a 16-bit word, closing a word
// early when a sentence terminator arrives.
module pos_packer
  import pos_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  in_pos,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic [1:0]  out_cnt
);

  packerState_t r_state;
  packerState_t w_nextState;

  logic [4:0] w_fifoDout;
  logic       w_fifoFull;
  logic       w_fifoEmpty;
  logic       w_push;
  logic       w_pop;
  logic       w_headTerm;

  logic [4:0] r_slot0;
  logic [4:0] r_slot1;
  logic [4:0] r_slot2;
  logic       r_flag;
  logic [1:0] r_cnt;

  // A handshake seen while reset is high is dropped rather than queued.
  assign w_push     = in_valid & ~w_fifoFull & ~rst;
  assign w_headTerm = isTerminator(w_fifoDout);

  pos_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_din  (in_pos),
    .i_pop  (w_pop),
    .o_dout (w_fifoDout),
    .o_full (w_fifoFull),
    .o_empty(w_fifoEmpty)
  );

  // State register for the packer FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL0;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and pop decision: one pop per fill cycle, none while emitting.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    case (r_state)
      FILL0: begin
        if (!w_fifoEmpty) begin
          w_pop       = 1'b1;
          w_nextState = w_headTerm ? EMIT : FILL1;
        end
      end
      FILL1: begin
        if (!w_fifoEmpty) begin
          w_pop       = 1'b1;
          w_nextState = w_headTerm ? EMIT : FILL2;
        end
      end
      FILL2: begin
        if (!w_fifoEmpty) begin
          w_pop       = 1'b1;
          w_nextState = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          w_nextState = FILL0;
        end
      end
      default: begin
        w_nextState = FILL0;
      end
    endcase
  end

  // Slot, flag and count registers: loaded on each pop, cleared when the word is taken.
  always_ff @(posedge clk) begin
    if (rst || ((r_state == EMIT) && out_ready)) begin
      r_slot0 <= POS_SPACE;
      r_slot1 <= POS_SPACE;
      r_slot2 <= POS_SPACE;
      r_flag  <= 1'b0;
      r_cnt   <= 2'd0;
    end else if (w_pop) begin
      case (r_state)
        FILL0:   r_slot0 <= w_fifoDout;
        FILL1:   r_slot1 <= w_fifoDout;
        FILL2:   r_slot2 <= w_fifoDout;
        default: r_slot0 <= r_slot0;
      endcase
      r_cnt  <= r_cnt + 2'd1;
      r_flag <= w_headTerm;
    end
  end

  // While reset is asserted the outputs present the idle values immediately,
  // before the first reset edge has cleared the registers.
  assign in_ready  = ~w_fifoFull | rst;
  assign out_valid = (r_state == EMIT) & ~rst;
  assign out_word  = rst ? 16'h0000 : {r_flag, r_slot2, r_slot1, r_slot0};
  assign out_cnt   = rst ? 2'b00 : r_cnt;

endmodule

// File: tb/tb_pos_packer.sv
// Self-checking bench for pos_packer: directed cases plus randomized traffic
// scored against a word-building reference model.
module tb_pos_packer;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_pos;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [1:0]  out_cnt;

  int checksTotal  = 0;
  int checksPassed = 0;

  typedef struct {
    logic [15:0] word;
    logic [1:0]  cnt;
  } expWord_t;

  expWord_t    expQ[$];
  logic [15:0] buildWord = 16'h0000;
  int          buildCnt  = 0;

  pos_packer #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_pos   (in_pos),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .out_cnt  (out_cnt)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Last-resort guard so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: every accepted code is appended to the word under
  // construction; a word closes after three codes or on a period/question mark.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      buildWord = 16'h0000;
      buildCnt  = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("sb_unexpected_word", expQ.size(), 1);
        end else begin
          expWord_t e;
          e = expQ.pop_front();
          checkOutput("sb_word", out_word, e.word);
          checkOutput("sb_cnt", out_cnt, e.cnt);
        end
      end
      if (in_valid && in_ready) begin
        buildWord = buildWord | (16'(in_pos) << (5 * buildCnt));
        buildCnt++;
        if (in_pos == 5'd30 || in_pos == 5'd31 || buildCnt == 3) begin
          expWord_t e;
          e.word = buildWord | ((in_pos >= 5'd30) ? 16'h8000 : 16'h0000);
          e.cnt  = 2'(buildCnt);
          expQ.push_back(e);
          buildWord = 16'h0000;
          buildCnt  = 0;
        end
      end
    end
  end

  // Offers one code and holds it until accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic [4:0] code);
    bit accepted = 1'b0;
    in_valid = 1'b1;
    in_pos   = code;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      checkOutput("in_ready_timeout", in_ready, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits (bounded) until a word is presented; leaves the caller at a negedge.
  task automatic waitOutValid(input string tag);
    bit seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checkOutput({tag, "_timeout"}, out_valid, 1);
    end
  endtask

  // Waits (bounded) until every modelled word has been delivered.
  task automatic drainScoreboard(input string tag);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (expQ.size() == 0) break;
    end
    checkOutput(tag, expQ.size(), 0);
  endtask

  initial begin
    int accepts;
    int accepted;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pos    = 5'd0;
    out_ready = 1'b1;

    // Reset values, both during and after reset.
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_word", out_word, 16'h0000);
    checkOutput("rst_out_cnt", out_cnt, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_out_valid", out_valid, 0);
    checkOutput("post_rst_out_word", out_word, 16'h0000);
    @(posedge clk);
    #1;

    // Three back-to-back codes: word appears exactly in cycle 4.
    applyStimulus(5'd8);
    applyStimulus(5'd9);
    applyStimulus(5'd0);
    @(negedge clk);
    checkOutput("lat_cycle3_not_valid", out_valid, 0);
    @(negedge clk);
    checkOutput("lat_cycle4_valid", out_valid, 1);
    checkOutput("word_8_9_0", out_word, 16'h0128);
    checkOutput("cnt_8_9_0", out_cnt, 2'd3);
    @(posedge clk);
    #1;

    // Early close on a period: slot 2 stays clear.
    applyStimulus(5'd8);
    applyStimulus(5'd30);
    waitOutValid("period");
    checkOutput("word_8_period", out_word, 16'h83C8);
    checkOutput("cnt_8_period", out_cnt, 2'd2);
    @(posedge clk);
    #1;

    // Commas never close a word; the question mark in slot 2 sets the flag.
    applyStimulus(5'd29);
    applyStimulus(5'd29);
    applyStimulus(5'd31);
    waitOutValid("comma");
    checkOutput("word_comma_qmark", out_word, 16'hFFBD);
    checkOutput("cnt_comma_qmark", out_cnt, 2'd3);
    @(posedge clk);
    #1;

    // Backpressure: with the output stalled, input stops after slots plus FIFO fill up.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    accepts   = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      in_pos = 5'(accepts + 1);
      @(negedge clk);
      if (!in_ready) break;
      @(posedge clk);
      #1;
      accepts++;
      if (accepts == 10) break;
    end
    checkOutput("fill_accepts", accepts, 3 + FIFO_DEPTH);
    checkOutput("stall_valid", out_valid, 1);
    checkOutput("stall_word", out_word, 16'h0C41);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_hold_word", out_word, 16'h0C41);
      checkOutput("stall_hold_cnt", out_cnt, 2'd3);
      checkOutput("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int c = accepts + 1; c <= 10; c++) begin
      applyStimulus(5'(c));
    end
    applyStimulus(5'd30);
    drainScoreboard("stall_drain");
    @(posedge clk);
    #1;

    // Reset in the middle of a word discards it and any coincident handshake.
    applyStimulus(5'd5);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_pos   = 5'd9;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_out_word", out_word, 16'h0000);
      checkOutput("midrst_out_cnt", out_cnt, 2'b00);
      checkOutput("midrst_in_ready", in_ready, 1);
    end
    @(posedge clk);
    #1;
    applyStimulus(5'd6);
    applyStimulus(5'd7);
    applyStimulus(5'd30);
    waitOutValid("midrst");
    checkOutput("midrst_word", out_word, 16'hF8E6);
    checkOutput("midrst_cnt", out_cnt, 2'd3);
    @(posedge clk);
    #1;

    // Randomized valid/ready stalls over 1000 codes, scored by the model.
    accepted = 0;
    for (int cyc = 0; cyc < 20000 && accepted < 1000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        in_pos = ($urandom_range(0, 1) == 0) ? 5'd30 : 5'd31;
      end else begin
        in_pos = 5'($urandom_range(0, 29));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid && in_ready) accepted++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("rand_accept_count", accepted, 1000);
    applyStimulus(5'd31);
    drainScoreboard("rand_drain");
    @(negedge clk);
    checkOutput("rand_idle_valid", out_valid, 0);
    checkOutput("rand_idle_cnt", out_cnt, 2'b00);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
